fproc_meas_responder: RTL
=========================

Name: fproc_meas_responder

Overview:
- Responder end of the fproc interface. Each processor core raises fproc_enable with an fproc_id; this block answers with fproc_ready and fproc_data.
- Results come from the measurement units' discriminated outputs: a 1-bit state plus a valid strobe per unit.
- Sits between the meas_unit array and the core array. It serves every core in parallel and stalls any core whose requested result has not yet arrived.

Parameters:
- N_CORES, 8, number of requesting processor cores.
- N_MEAS_UNIT, 8, number of measurement channels; valid ids are 0..N_MEAS_UNIT-1.
- DATA_WIDTH, 32, width of fproc_data.
- FPROC_ID_WIDTH, 8, width of fproc_id.

Ports:
- clk  input  1  single clock for the whole block.
- reset  input  1  asynchronous, active-low reset.
- meas  input  [N_MEAS_UNIT-1:0]  discriminated state bit, one per unit.
- meas_valid  input  [N_MEAS_UNIT-1:0]  one-cycle strobe; meas[k] is valid when meas_valid[k]=1.
- fproc_enable  input  [0:0] x N_CORES  request strobe from each core.
- fproc_id  input  [FPROC_ID_WIDTH-1:0] x N_CORES  channel requested; sampled when enable=1.
- fproc_ready  output  [0:0] x N_CORES  one-cycle response strobe.
- fproc_data  output  [DATA_WIDTH-1:0] x N_CORES  response data; held between responses.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - all result registers = 0 and all fresh bits = 0;
  - all cores in IDLE;
  - fproc_ready = 0 and fproc_data = 0.
- Result store, per channel k:
  - 1-bit result register res[k].
  - Fresh bits fresh[c][k], one per core.
  - meas_valid[k]=1: res[k] <= meas[k] and fresh[c][k] <= 1 for every core c.
- Per-core FSM, states IDLE and WAIT. Per core: latched id lid, 1-bit data register.
- IDLE, enable=1, id >= N_MEAS_UNIT:
  - next cycle fproc_ready=1, fproc_data=0;
  - stay IDLE.
- IDLE, enable=1, id valid, fresh[c][id]=1 or meas_valid[id]=1 this cycle:
  - next cycle fproc_ready=1;
  - fproc_data = zero-extended value res[id] holds after this cycle's update (the new measurement wins on coincidence);
  - fresh[c][id] cleared (a concurrent set is overridden by this consume); stay IDLE.
- IDLE, enable=1, id valid, neither condition true: latch lid, go to WAIT.
- WAIT:
  - on meas_valid[lid]=1: next cycle fproc_ready=1, fproc_data = zero-extended meas[lid], fresh[c][lid] cleared, go to IDLE;
  - otherwise stay in WAIT.
- fproc_enable while in WAIT is ignored: no queueing, no error.
- Latency:
  - fresh hit: enable at cycle t gives ready at t+1;
  - stall: meas_valid at cycle w gives ready at w+1;
  - ready is never asserted in the same cycle as enable.
- fproc_ready is high exactly one cycle per accepted request. fproc_data changes only in cycles where ready=1.
- Cores are independent:
  - multiple cores may consume the same channel; each consumes its own fresh bit;
  - simultaneous requests to the same channel all respond in the same cycle.
- A new meas_valid on a fresh, unconsumed channel overwrites res; only the latest value is ever returned.
- Reset asserted mid-WAIT aborts the request: the core returns to IDLE and no response is produced.

Test Plan:
- Fresh hit: reset, meas_valid[2]=1 with meas[2]=1; later core0 enable with id=2 -> ready at t+1, data=32'h1; a second request on id=2 stalls in WAIT.
- Stall: core3 requests id=5 with no prior result; after 10 cycles meas_valid[5]=1, meas[5]=0 -> ready exactly 1 cycle later, data=0, zero ready pulses before that.
- Coincidence: core1 enable id=4 in the same cycle as meas_valid[4]=1, meas=1 (old res=0, fresh=1) -> ready at t+1, data=1, fresh[1][4]=0 afterward.
- Fan-out: cores 0..7 all request id=0 in the same cycle, channel 0 fresh=1 for all -> all eight ready on the same cycle with identical data; core0's next request on id=0 stalls.
- Bad id: core2 id=8 (N_MEAS_UNIT=8) -> ready at t+1, data=0, state stays IDLE; enable pulsed during a WAIT on another core -> that core's response unaffected.
- Reset mid-WAIT: core6 waiting on id=1, assert reset for 2 cycles, release, then meas_valid[1]=1 -> no ready on core6; outputs stay 0.

Source files
------------

// File: rtl/fproc_meas_responder.sv
// Answers per-core fproc requests from discriminated measurement results. Fresh hits respond one cycle
// after enable. Misses stall the core in WAIT and respond one cycle after the channel's next meas_valid.
module fproc_meas_responder #(
  parameter int N_CORES        = 8,
  parameter int N_MEAS_UNIT    = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int FPROC_ID_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_MEAS_UNIT-1:0]    meas,
  input  logic [N_MEAS_UNIT-1:0]    meas_valid,
  input  logic [N_CORES-1:0]        fproc_enable,
  input  logic [FPROC_ID_WIDTH-1:0] fproc_id [N_CORES],
  output logic [N_CORES-1:0]        fproc_ready,
  output logic [DATA_WIDTH-1:0]     fproc_data [N_CORES]
);

  localparam int CW = (N_MEAS_UNIT > 1) ? $clog2(N_MEAS_UNIT) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  logic [N_MEAS_UNIT-1:0] res_q;
  logic [N_MEAS_UNIT-1:0] res_nxt;

  // A measurement arriving this cycle wins over the stored result.
  assign res_nxt = (meas_valid & meas) | (~meas_valid & res_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_q <= '0;
    end else begin
      res_q <= res_nxt;
    end
  end

  for (genvar c = 0; c < N_CORES; c++) begin : g_core
    state_t                 state_q;
    logic [CW-1:0]          lid_q;
    logic                   rdy_q;
    logic                   dat_q;
    logic [N_MEAS_UNIT-1:0] fresh_q;
    logic [N_MEAS_UNIT-1:0] clr;
    logic [CW-1:0]          id_ch;
    logic                   id_ok;
    logic                   hit;

    always_comb begin
      id_ch = fproc_id[c][CW-1:0];
      id_ok = $unsigned(32'(fproc_id[c])) < $unsigned(32'(N_MEAS_UNIT));
      hit   = id_ok && (fresh_q[id_ch] || meas_valid[id_ch]);
      clr   = '0;
      // A consume in the same cycle as a new strobe leaves the fresh bit clear.
      if (state_q == IDLE && fproc_enable[c] && hit) clr[id_ch] = 1'b1;
      if (state_q == WAIT && meas_valid[lid_q])      clr[lid_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= IDLE;
        lid_q   <= '0;
        rdy_q   <= 1'b0;
        dat_q   <= 1'b0;
        fresh_q <= '0;
      end else begin
        rdy_q   <= 1'b0;
        fresh_q <= (fresh_q | meas_valid) & ~clr;
        case (state_q)
          IDLE: begin
            if (fproc_enable[c]) begin
              if (!id_ok) begin
                rdy_q <= 1'b1;
                dat_q <= 1'b0;
              end else if (hit) begin
                rdy_q <= 1'b1;
                dat_q <= res_nxt[id_ch];
              end else begin
                lid_q   <= id_ch;
                state_q <= WAIT;
              end
            end
          end
          WAIT: begin
            if (meas_valid[lid_q]) begin
              rdy_q   <= 1'b1;
              dat_q   <= meas[lid_q];
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    assign fproc_ready[c] = rdy_q;
    assign fproc_data[c]  = DATA_WIDTH'(dat_q);
  end

endmodule
